// File: rtl/riscv_pkg.sv
// Shared RV32I decode-stage definitions: opcodes, ALU-op encoding, control and ID/EX payloads.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned OPC_W    = 7;
    localparam int unsigned FUNCT_W  = 4;

    localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        alu_src:    1'b0,
        alu_op:     ALU_ADD
    };

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
        logic [REG_AW-1:0]  rd;
        logic [FUNCT_W-1:0] funct;
        ctrl_t              ctrl;
    } id_ex_t;

    function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
        return {{(XLEN-12){v[11]}}, v};
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two async read ports, one write port, x0 hardwired to zero,
// same-cycle write-through so ID sees the value WB is retiring.
module register_file
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    output logic [XLEN-1:0]   rs1_data_o,
    output logic [XLEN-1:0]   rs2_data_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wr_addr_i,
    input  logic [XLEN-1:0]   wr_data_i
);

    logic [NUM_REGS-1:0][XLEN-1:0] regs_q;
    logic                          wr_en;

    assign wr_en = we_i && (wr_addr_i != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '0;
        end else if (wr_en) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Address 0 wins over the bypass so a WB to x0 never leaks through.
    always_comb begin
        rs1_data_o = regs_q[rs1_addr_i];
        if (rs1_addr_i == '0) begin
            rs1_data_o = '0;
        end else if (wr_en && (wr_addr_i == rs1_addr_i)) begin
            rs1_data_o = wr_data_i;
        end
    end

    always_comb begin
        rs2_data_o = regs_q[rs2_addr_i];
        if (rs2_addr_i == '0) begin
            rs2_data_o = '0;
        end else if (wr_en && (wr_addr_i == rs2_addr_i)) begin
            rs2_data_o = wr_data_i;
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// ID stage of the 5-stage RV32I pipe: decode, register file, beq resolution,
// load-use / branch-operand hazard detection and the ID/EX pipeline register.
module instruction_decode
    import riscv_pkg::*;
#(
    parameter bit FLUSH_ON_TAKEN = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [XLEN-1:0]    IF_ID_pc,
    input  logic [XLEN-1:0]    IF_ID_inst,
    input  logic               WB_reg_write,
    input  logic [REG_AW-1:0]  WB_rd,
    input  logic [XLEN-1:0]    WB_data,
    input  logic               EX_MEM_reg_write,
    input  logic               EX_MEM_mem_read,
    input  logic [REG_AW-1:0]  EX_MEM_rd,
    input  logic [XLEN-1:0]    EX_MEM_alu_result,
    output logic [XLEN-1:0]    pc_branch,
    output logic               pc_src,
    output logic               pc_write,
    output logic               IF_ID_write,
    output logic               IF_flush,
    output logic [XLEN-1:0]    ID_EX_pc,
    output logic [XLEN-1:0]    ID_EX_rs1_data,
    output logic [XLEN-1:0]    ID_EX_rs2_data,
    output logic [XLEN-1:0]    ID_EX_imm,
    output logic [REG_AW-1:0]  ID_EX_rs1,
    output logic [REG_AW-1:0]  ID_EX_rs2,
    output logic [REG_AW-1:0]  ID_EX_rd,
    output logic [FUNCT_W-1:0] ID_EX_funct,
    output logic               ID_EX_reg_write,
    output logic               ID_EX_mem_read,
    output logic               ID_EX_mem_write,
    output logic               ID_EX_mem_to_reg,
    output logic               ID_EX_alu_src,
    output logic [1:0]         ID_EX_alu_op
);

    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;

    assign opcode = IF_ID_inst[6:0];
    assign rd     = IF_ID_inst[11:7];
    assign funct3 = IF_ID_inst[14:12];
    assign rs1    = IF_ID_inst[19:15];
    assign rs2    = IF_ID_inst[24:20];

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;

    assign imm_i = sext12(IF_ID_inst[31:20]);
    assign imm_s = sext12({IF_ID_inst[31:25], IF_ID_inst[11:7]});
    assign imm_b = {{(XLEN-13){IF_ID_inst[31]}}, IF_ID_inst[31], IF_ID_inst[7],
                    IF_ID_inst[30:25], IF_ID_inst[11:8], 1'b0};

    // Opcode decode; anything unrecognised is treated as a bubble.
    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic            dec_valid;
    logic            dec_beq;
    logic            dec_uses_rs2;

    always_comb begin
        dec_ctrl     = CTRL_NONE;
        dec_imm      = '0;
        dec_valid    = 1'b0;
        dec_beq      = 1'b0;
        dec_uses_rs2 = 1'b0;
        unique case (opcode)
            OP_R: begin
                dec_valid          = 1'b1;
                dec_uses_rs2       = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = ALU_FUNCT;
            end
            OP_I: begin
                dec_valid          = 1'b1;
                dec_imm            = imm_i;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = ALU_FUNCT;
            end
            OP_LOAD: begin
                dec_valid           = 1'b1;
                dec_imm             = imm_i;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
            end
            OP_STORE: begin
                dec_valid          = 1'b1;
                dec_uses_rs2       = 1'b1;
                dec_imm            = imm_s;
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
            end
            OP_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    dec_valid       = 1'b1;
                    dec_beq         = 1'b1;
                    dec_uses_rs2    = 1'b1;
                    dec_imm         = imm_b;
                    dec_ctrl.alu_op = ALU_SUB;
                end
            end
            default: begin
                dec_valid = 1'b0;
            end
        endcase
    end

    logic [XLEN-1:0] rf_rs1_data;
    logic [XLEN-1:0] rf_rs2_data;

    register_file u_register_file (
        .clk        (clk),
        .reset_n    (reset_n),
        .rs1_addr_i (rs1),
        .rs2_addr_i (rs2),
        .rs1_data_o (rf_rs1_data),
        .rs2_data_o (rf_rs2_data),
        .we_i       (WB_reg_write),
        .wr_addr_i  (WB_rd),
        .wr_data_i  (WB_data)
    );

    id_ex_t id_ex_d;
    id_ex_t id_ex_q;

    // Hazard detection against the instruction now in EX and the one in MEM.
    logic ex_rd_nz;
    logic ex_hit_rs1;
    logic ex_hit_rs2;
    logic mem_rd_nz;
    logic mem_hit_rs1;
    logic mem_hit_rs2;
    logic load_use_stall;
    logic branch_stall;
    logic stall;

    assign ex_rd_nz    = (id_ex_q.rd != '0);
    assign ex_hit_rs1  = ex_rd_nz && (id_ex_q.rd == rs1);
    assign ex_hit_rs2  = ex_rd_nz && (id_ex_q.rd == rs2);
    assign mem_rd_nz   = (EX_MEM_rd != '0);
    assign mem_hit_rs1 = mem_rd_nz && (EX_MEM_rd == rs1);
    assign mem_hit_rs2 = mem_rd_nz && (EX_MEM_rd == rs2);

    assign load_use_stall = dec_valid && id_ex_q.ctrl.mem_read
                          && (ex_hit_rs1 || (dec_uses_rs2 && ex_hit_rs2));
    assign branch_stall   = dec_beq
                          && ((id_ex_q.ctrl.reg_write && (ex_hit_rs1 || ex_hit_rs2))
                           || (EX_MEM_mem_read && (mem_hit_rs1 || mem_hit_rs2)));
    assign stall          = load_use_stall || branch_stall;

    // beq compare takes an ALU result sitting in EX/MEM; loads there have already stalled us.
    logic            fwd_ok;
    logic [XLEN-1:0] cmp_a;
    logic [XLEN-1:0] cmp_b;

    assign fwd_ok = EX_MEM_reg_write && !EX_MEM_mem_read;
    assign cmp_a  = (fwd_ok && mem_hit_rs1) ? EX_MEM_alu_result : rf_rs1_data;
    assign cmp_b  = (fwd_ok && mem_hit_rs2) ? EX_MEM_alu_result : rf_rs2_data;

    assign pc_branch   = IF_ID_pc + imm_b;
    assign pc_src      = dec_beq && (cmp_a == cmp_b) && !stall;
    assign pc_write    = !stall;
    assign IF_ID_write = !stall;
    assign IF_flush    = pc_src && FLUSH_ON_TAKEN;

    // ID/EX next value: a full bubble on stall or an unrecognised instruction.
    always_comb begin
        id_ex_d = '0;
        if (dec_valid && !stall) begin
            id_ex_d.pc       = IF_ID_pc;
            id_ex_d.rs1_data = rf_rs1_data;
            id_ex_d.rs2_data = rf_rs2_data;
            id_ex_d.imm      = dec_imm;
            id_ex_d.rs1      = rs1;
            id_ex_d.rs2      = rs2;
            id_ex_d.rd       = rd;
            id_ex_d.funct    = {IF_ID_inst[30], funct3};
            id_ex_d.ctrl     = dec_ctrl;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign ID_EX_pc         = id_ex_q.pc;
    assign ID_EX_rs1_data   = id_ex_q.rs1_data;
    assign ID_EX_rs2_data   = id_ex_q.rs2_data;
    assign ID_EX_imm        = id_ex_q.imm;
    assign ID_EX_rs1        = id_ex_q.rs1;
    assign ID_EX_rs2        = id_ex_q.rs2;
    assign ID_EX_rd         = id_ex_q.rd;
    assign ID_EX_funct      = id_ex_q.funct;
    assign ID_EX_reg_write  = id_ex_q.ctrl.reg_write;
    assign ID_EX_mem_read   = id_ex_q.ctrl.mem_read;
    assign ID_EX_mem_write  = id_ex_q.ctrl.mem_write;
    assign ID_EX_mem_to_reg = id_ex_q.ctrl.mem_to_reg;
    assign ID_EX_alu_src    = id_ex_q.ctrl.alu_src;
    assign ID_EX_alu_op     = id_ex_q.ctrl.alu_op;

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed scenarios then random traffic
// against a behavioural model of decode, register file and hazard rules.
module tb_instruction_decode;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [31:0] IF_ID_pc, IF_ID_inst;
    logic        WB_reg_write;
    logic [4:0]  WB_rd;
    logic [31:0] WB_data;
    logic        EX_MEM_reg_write, EX_MEM_mem_read;
    logic [4:0]  EX_MEM_rd;
    logic [31:0] EX_MEM_alu_result;

    logic [31:0] pc_branch, ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
    logic        pc_src, pc_write, IF_ID_write, IF_flush;
    logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic [3:0]  ID_EX_funct;
    logic        ID_EX_reg_write, ID_EX_mem_read, ID_EX_mem_write, ID_EX_mem_to_reg, ID_EX_alu_src;
    logic [1:0]  ID_EX_alu_op;

    logic [31:0] f_pc_branch, f_ID_EX_pc, f_ID_EX_rs1_data, f_ID_EX_rs2_data, f_ID_EX_imm;
    logic        f_pc_src, f_pc_write, f_IF_ID_write, f_IF_flush;
    logic [4:0]  f_ID_EX_rs1, f_ID_EX_rs2, f_ID_EX_rd;
    logic [3:0]  f_ID_EX_funct;
    logic        f_ID_EX_reg_write, f_ID_EX_mem_read, f_ID_EX_mem_write, f_ID_EX_mem_to_reg, f_ID_EX_alu_src;
    logic [1:0]  f_ID_EX_alu_op;

    instruction_decode u_dut (
        .clk(clk), .reset_n(reset_n), .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst),
        .WB_reg_write(WB_reg_write), .WB_rd(WB_rd), .WB_data(WB_data),
        .EX_MEM_reg_write(EX_MEM_reg_write), .EX_MEM_mem_read(EX_MEM_mem_read),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_alu_result(EX_MEM_alu_result),
        .pc_branch(pc_branch), .pc_src(pc_src), .pc_write(pc_write),
        .IF_ID_write(IF_ID_write), .IF_flush(IF_flush),
        .ID_EX_pc(ID_EX_pc), .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
        .ID_EX_imm(ID_EX_imm), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ID_EX_funct(ID_EX_funct), .ID_EX_reg_write(ID_EX_reg_write),
        .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_mem_write(ID_EX_mem_write),
        .ID_EX_mem_to_reg(ID_EX_mem_to_reg), .ID_EX_alu_src(ID_EX_alu_src),
        .ID_EX_alu_op(ID_EX_alu_op)
    );

    instruction_decode #(.FLUSH_ON_TAKEN(1'b1)) u_dut_flush (
        .clk(clk), .reset_n(reset_n), .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst),
        .WB_reg_write(WB_reg_write), .WB_rd(WB_rd), .WB_data(WB_data),
        .EX_MEM_reg_write(EX_MEM_reg_write), .EX_MEM_mem_read(EX_MEM_mem_read),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_alu_result(EX_MEM_alu_result),
        .pc_branch(f_pc_branch), .pc_src(f_pc_src), .pc_write(f_pc_write),
        .IF_ID_write(f_IF_ID_write), .IF_flush(f_IF_flush),
        .ID_EX_pc(f_ID_EX_pc), .ID_EX_rs1_data(f_ID_EX_rs1_data), .ID_EX_rs2_data(f_ID_EX_rs2_data),
        .ID_EX_imm(f_ID_EX_imm), .ID_EX_rs1(f_ID_EX_rs1), .ID_EX_rs2(f_ID_EX_rs2), .ID_EX_rd(f_ID_EX_rd),
        .ID_EX_funct(f_ID_EX_funct), .ID_EX_reg_write(f_ID_EX_reg_write),
        .ID_EX_mem_read(f_ID_EX_mem_read), .ID_EX_mem_write(f_ID_EX_mem_write),
        .ID_EX_mem_to_reg(f_ID_EX_mem_to_reg), .ID_EX_alu_src(f_ID_EX_alu_src),
        .ID_EX_alu_op(f_ID_EX_alu_op)
    );

    typedef struct packed {
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  funct;
        logic        rw, mr, mw, m2r, asrc;
        logic [1:0]  aop;
    } idex_t;

    idex_t dut_idex;
    assign dut_idex = {ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm,
                       ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_funct,
                       ID_EX_reg_write, ID_EX_mem_read, ID_EX_mem_write,
                       ID_EX_mem_to_reg, ID_EX_alu_src, ID_EX_alu_op};

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [31:0] m_regs [32];
    idex_t       m_idex;

    logic        obs_pc_src, obs_pc_write, obs_flush, obs_flush1;
    logic [31:0] obs_branch;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (WB_reg_write && WB_rd == r) return WB_data;
        return m_regs[r];
    endfunction

    function automatic logic m_ex_fwd(input logic [4:0] r);
        return EX_MEM_reg_write && !EX_MEM_mem_read && EX_MEM_rd != 5'd0 && EX_MEM_rd == r;
    endfunction

    // Reference behaviour from the instruction-set rules, using the model's own ID/EX copy.
    task automatic model_comb(output idex_t nxt, output logic stall, output logic take,
                              output logic [31:0] tgt);
        logic [6:0]  op;
        logic [4:0]  a, b, prd;
        logic        beq, valid, uses2, ex_match, mem_match;
        logic [31:0] va, vb, ca, cb, immi, imms, immb;
        op   = IF_ID_inst[6:0];
        a    = IF_ID_inst[19:15];
        b    = IF_ID_inst[24:20];
        immi = 32'($signed(IF_ID_inst[31:20]));
        imms = 32'($signed({IF_ID_inst[31:25], IF_ID_inst[11:7]}));
        immb = 32'($signed({IF_ID_inst[31], IF_ID_inst[7], IF_ID_inst[30:25], IF_ID_inst[11:8], 1'b0}));
        tgt  = IF_ID_pc + immb;
        beq   = (op == 7'b1100011) && (IF_ID_inst[14:12] == 3'd0);
        valid = (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011)
              || (op == 7'b0100011) || beq;
        uses2 = (op == 7'b0110011) || (op == 7'b0100011) || beq;
        va = m_read(a);
        vb = m_read(b);
        prd = m_idex.rd;
        ex_match  = prd != 5'd0 && (prd == a || prd == b);
        mem_match = EX_MEM_rd != 5'd0 && (EX_MEM_rd == a || EX_MEM_rd == b);
        stall = valid && m_idex.mr && prd != 5'd0 && (prd == a || (uses2 && prd == b));
        if (beq && ((m_idex.rw && ex_match) || (EX_MEM_mem_read && mem_match))) stall = 1'b1;
        ca = m_ex_fwd(a) ? EX_MEM_alu_result : va;
        cb = m_ex_fwd(b) ? EX_MEM_alu_result : vb;
        take = beq && (ca == cb) && !stall;
        nxt = '0;
        if (valid && !stall) begin
            nxt.pc    = IF_ID_pc;
            nxt.rs1d  = va;
            nxt.rs2d  = vb;
            nxt.rs1   = a;
            nxt.rs2   = b;
            nxt.rd    = IF_ID_inst[11:7];
            nxt.funct = {IF_ID_inst[30], IF_ID_inst[14:12]};
            if (op == 7'b0110011) begin
                nxt.rw = 1'b1; nxt.aop = 2'b10;
            end else if (op == 7'b0010011) begin
                nxt.rw = 1'b1; nxt.asrc = 1'b1; nxt.aop = 2'b10; nxt.imm = immi;
            end else if (op == 7'b0000011) begin
                nxt.rw = 1'b1; nxt.mr = 1'b1; nxt.m2r = 1'b1; nxt.asrc = 1'b1; nxt.imm = immi;
            end else if (op == 7'b0100011) begin
                nxt.mw = 1'b1; nxt.asrc = 1'b1; nxt.imm = imms;
            end else begin
                nxt.aop = 2'b01; nxt.imm = immb;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_idex = '0;
    endtask

    // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
    task automatic cycle();
        idex_t       nxt;
        logic        st, tk;
        logic [31:0] tg;
        model_comb(nxt, st, tk, tg);
        #1;
        obs_pc_src   = pc_src;
        obs_pc_write = pc_write;
        obs_flush    = IF_flush;
        obs_flush1   = f_IF_flush;
        obs_branch   = pc_branch;
        chk("fetch_ctrl", {pc_src, pc_write, IF_ID_write, IF_flush, f_IF_flush},
            {tk, !st, !st, 1'b0, tk});
        chk("pc_branch", pc_branch, tg);
        @(posedge clk);
        m_idex = nxt;
        if (WB_reg_write && WB_rd != 5'd0) m_regs[WB_rd] = WB_data;
        #1;
        chk("id_ex", dut_idex, m_idex);
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        IF_ID_inst = 32'd0; WB_reg_write = 1'b1; WB_rd = r; WB_data = d;
        cycle();
        WB_reg_write = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        r[11:7]  = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 8))
            0: r[6:0] = 7'b0110011;
            1: r[6:0] = 7'b0010011;
            2: r[6:0] = 7'b0000011;
            3: r[6:0] = 7'b0100011;
            4, 5: begin r[6:0] = 7'b1100011; r[14:12] = 3'd0; end
            6: r = 32'd0;
            7: r[6:0] = 7'b0110111;
            default: begin r[6:0] = 7'b1100011; r[14:12] = 3'd1; end
        endcase
        return r;
    endfunction

    initial begin
        reset_n = 1'b0;
        IF_ID_pc = 32'd0; IF_ID_inst = 32'd0;
        WB_reg_write = 1'b0; WB_rd = 5'd0; WB_data = 32'd0;
        EX_MEM_reg_write = 1'b0; EX_MEM_mem_read = 1'b0; EX_MEM_rd = 5'd0; EX_MEM_alu_result = 32'd0;
        model_reset();
        #12;
        chk("reset_id_ex", dut_idex, 154'd0);
        chk("reset_fetch", {pc_write, IF_ID_write, pc_src, IF_flush, f_IF_flush}, 5'b11000);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // add x8,x12,x14
        wb(5'd12, 32'd3);
        wb(5'd14, 32'd4);
        IF_ID_pc = 32'h10; IF_ID_inst = 32'h00E60433;
        cycle();
        chk("add_rs1", ID_EX_rs1_data, 32'd3);
        chk("add_rs2", ID_EX_rs2_data, 32'd4);
        chk("add_rd_ctrl", {ID_EX_rd, ID_EX_reg_write, ID_EX_alu_op}, {5'd8, 1'b1, 2'b10});

        // lw x14,8(x2) then add x5,x19,x14: one stall cycle
        IF_ID_pc = 32'h14; IF_ID_inst = 32'h00812703;
        cycle();
        IF_ID_pc = 32'h18; IF_ID_inst = 32'h00E982B3;
        cycle();
        chk("lu_stall", {obs_pc_write, obs_pc_src}, 2'b00);
        chk("lu_bubble", dut_idex, 154'd0);
        cycle();
        chk("lu_issue", {ID_EX_rd, ID_EX_reg_write}, {5'd5, 1'b1});

        // beq x1,x10,+12 taken / not taken
        wb(5'd1, 32'd5);
        wb(5'd10, 32'd5);
        IF_ID_pc = 32'h1C; IF_ID_inst = 32'h00A08663;
        cycle();
        chk("beq_taken", {obs_pc_src, obs_branch, obs_flush, obs_flush1}, {1'b1, 32'h28, 1'b0, 1'b1});
        wb(5'd10, 32'd6);
        IF_ID_pc = 32'h1C; IF_ID_inst = 32'h00A08663;
        cycle();
        chk("beq_not_taken", {obs_pc_src, obs_branch, obs_flush1}, {1'b0, 32'h28, 1'b0});

        // sw x7,12(x5) with x7 retiring in the same cycle; then WB to x0
        IF_ID_inst = 32'h0072A623; WB_reg_write = 1'b1; WB_rd = 5'd7; WB_data = 32'hAA;
        cycle();
        chk("sw_bypass", {ID_EX_rs2_data, ID_EX_imm, ID_EX_mem_write}, {32'hAA, 32'd12, 1'b1});
        IF_ID_inst = 32'h00000433; WB_rd = 5'd0; WB_data = 32'h55;
        cycle();
        WB_reg_write = 1'b0;
        chk("x0_write", {ID_EX_rs1_data, ID_EX_rs2_data}, 64'd0);

        // beq x1,x14 right behind lw x14: two stall cycles, then bypassed compare
        IF_ID_inst = 32'h00812703;
        cycle();
        IF_ID_pc = 32'h1C; IF_ID_inst = 32'h00E08663;
        cycle();
        chk("beq_ld_stall1", obs_pc_write, 1'b0);
        EX_MEM_reg_write = 1'b1; EX_MEM_mem_read = 1'b1; EX_MEM_rd = 5'd14;
        cycle();
        chk("beq_ld_stall2", obs_pc_write, 1'b0);
        EX_MEM_reg_write = 1'b0; EX_MEM_mem_read = 1'b0; EX_MEM_rd = 5'd0;
        WB_reg_write = 1'b1; WB_rd = 5'd14; WB_data = 32'd5;
        cycle();
        WB_reg_write = 1'b0;
        chk("beq_ld_taken", {obs_pc_src, obs_pc_write}, 2'b11);

        // reset asserted during a stall
        IF_ID_inst = 32'h00812703;
        cycle();
        IF_ID_inst = 32'h00E08663;
        #1;
        chk("pre_reset_stall", pc_write, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("async_reset", dut_idex, 154'd0);
        model_reset();
        IF_ID_inst = 32'd0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("post_reset_fetch", {pc_write, IF_ID_write, pc_src, IF_flush}, 4'b1100);
        IF_ID_inst = 32'h00E08433;
        cycle();
        chk("regs_cleared", {ID_EX_rs1_data, ID_EX_rs2_data}, 64'd0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            IF_ID_pc          = {$urandom_range(0, 1023), 2'b00};
            IF_ID_inst        = rand_inst();
            WB_reg_write      = 1'($urandom_range(0, 1));
            WB_rd             = 5'($urandom_range(0, 7));
            WB_data           = 32'($urandom_range(0, 3));
            EX_MEM_reg_write  = 1'($urandom_range(0, 1));
            EX_MEM_mem_read   = ($urandom_range(0, 3) == 0);
            EX_MEM_rd         = 5'($urandom_range(0, 7));
            EX_MEM_alu_result = 32'($urandom_range(0, 3));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
